// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding, default frame geometry and the 2-of-3 vote.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; 2 clk latency, no flow control.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic nReset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx_oversampler.sv
// Oversampling UART receiver: 2-of-3 mid-bit vote per bit, done/err pulse one clk after the stop decision.
// No backpressure: data is overwritten by the next good frame; the FSM advances only on en ticks.
module uart_rx_oversampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 syncReset,
  input  logic                 en,
  input  logic                 in,
  output logic [DATA_BITS-1:0] data,
  output logic                 done,
  output logic                 err,
  output logic                 busy
);

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int MID = OVERSAMPLE / 2;

  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_MIDM1 = CW'(MID - 1);
  localparam logic [CW-1:0] C_MID   = CW'(MID);
  localparam logic [CW-1:0] C_MIDP1 = CW'(MID + 1);
  localparam logic [CW-1:0] C_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_ONE   = BW'(1);
  localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);

  uart_state_e          r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_s0;
  logic                 r_s1;
  logic                 r_done;
  logic                 r_err;

  logic                 w_rxs;
  logic                 w_maj;
  logic [DATA_BITS-1:0] w_shift_next;

  sync2 #(
    .RST_VAL(1'b1)
  ) u_sync2 (
    .clk    (clk),
    .nReset (nReset),
    .i_d    (in),
    .o_q    (w_rxs)
  );

  // Third vote comes straight from the line on the decision tick.
  assign w_maj        = majority3(r_s0, r_s1, w_rxs);
  assign w_shift_next = (r_shift >> 1) | (DATA_BITS'(w_maj) << (DATA_BITS - 1));

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else if (syncReset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (en) begin
        if (r_cnt == C_MIDM1) r_s0 <= w_rxs;
        if (r_cnt == C_MID)   r_s1 <= w_rxs;
        case (r_state)
          ST_IDLE: begin
            if (!w_rxs) begin
              r_state <= ST_START;
              r_cnt   <= C_ONE;
            end else begin
              r_cnt   <= '0;
            end
          end
          ST_START: begin
            // Small OVERSAMPLE puts the vote on the last tick; a false start wins.
            if (r_cnt == C_MIDP1 && w_maj) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else if (r_cnt == C_LAST) begin
              r_state   <= ST_DATA;
              r_cnt     <= '0;
              r_bit_idx <= '0;
            end else begin
              r_cnt <= r_cnt + C_ONE;
            end
          end
          ST_DATA: begin
            if (r_cnt == C_MIDP1) r_shift <= w_shift_next;
            if (r_cnt == C_LAST) begin
              r_cnt <= '0;
              if (r_bit_idx == B_LAST) r_state   <= ST_STOP;
              else                     r_bit_idx <= r_bit_idx + B_ONE;
            end else begin
              r_cnt <= r_cnt + C_ONE;
            end
          end
          ST_STOP: begin
            if (r_cnt == C_MIDP1) begin
              r_cnt <= '0;
              if (w_maj) begin
                r_data  <= r_shift;
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end else begin
                r_err   <= 1'b1;
                r_state <= ST_BREAK;
              end
            end else begin
              r_cnt <= r_cnt + C_ONE;
            end
          end
          ST_BREAK: begin
            if (w_rxs) r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign data = r_data;
  assign done = r_done;
  assign err  = r_err;
  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Bench for uart_rx_oversampler: line driven one level per en tick, results compared to frame-level expectations.
module tb_uart_rx_oversampler;

  localparam int OS  = 16;
  localparam int DB  = 8;
  localparam int MID = OS / 2;

  logic          clk = 1'b0;
  logic          nReset = 1'b0;
  logic          syncReset = 1'b0;
  logic          en = 1'b0;
  logic          rx_in = 1'b1;
  logic [DB-1:0] data;
  logic          done;
  logic          err;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int tick_no  = 0;

  logic [7:0] obs_data_q[$];
  int         obs_dtick_q[$];
  int         obs_etick_q[$];
  int         both_cnt = 0;
  int         wide_cnt = 0;
  logic       prev_done = 1'b0;
  logic       prev_err  = 1'b0;
  logic [7:0] last_data = 8'h00;

  uart_rx_oversampler #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB)
  ) dut (
    .clk       (clk),
    .nReset    (nReset),
    .syncReset (syncReset),
    .en        (en),
    .in        (rx_in),
    .data      (data),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Observation only: records every done/err pulse with the tick number it follows.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      obs_data_q.push_back(data);
      obs_dtick_q.push_back(tick_no);
    end
    if (err === 1'b1) obs_etick_q.push_back(tick_no);
    if (done === 1'b1 && err === 1'b1) both_cnt++;
    if ((done === 1'b1 && prev_done === 1'b1) || (err === 1'b1 && prev_err === 1'b1)) wide_cnt++;
    prev_done = done;
    prev_err  = err;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One oversample period: line level set, 3 quiet clk, then a 1-clk en.
  task automatic tick(input logic lvl);
    rx_in = lvl;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    tick_no++;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic play_idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  function automatic logic frame_lvl(input logic [7:0] b, input logic stopb, input int t);
    int k;
    k = t / OS;
    if (k == 0) return 1'b0;
    if (k <= DB) return b[k-1];
    return stopb;
  endfunction

  // Decision en of a good frame is the vote tick of its stop bit.
  function automatic int decide_tick(input int start);
    return start + 9 * OS + MID + 1;
  endfunction

  task automatic play_frame(input logic [7:0] b, input logic stopb, input int gpos, output int start);
    start = tick_no + 1;
    for (int t = 0; t < 10 * OS; t++) begin
      logic l;
      l = frame_lvl(b, stopb, t);
      if (t == gpos) l = ~l;
      tick(l);
    end
  endtask

  task automatic clear_obs();
    obs_data_q.delete();
    obs_dtick_q.delete();
    obs_etick_q.delete();
  endtask

  task automatic test_reset();
    nReset = 1'b0; syncReset = 1'b0; en = 1'b0; rx_in = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h expected 00", data); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rx_in = 1'b0; en = 1'b1;
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL release_clk1_busy: got %b expected 0", busy); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL release_clk2_busy: got %b expected 0", busy); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL release_clk3_busy: got %b expected 1", busy); end
    en = 1'b0; rx_in = 1'b1; nReset = 1'b0;
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rereset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_frame_a5();
    int s;
    clear_obs();
    play_idle(4);
    play_frame(8'hA5, 1'b1, -1, s);
    play_idle(4);
    last_data = 8'hA5;
    n_checks++;
    if (obs_data_q.size() !== 1) begin
      n_errors++; $display("FAIL a5_done_count: got %0d expected 1", obs_data_q.size());
    end else begin
      n_checks++; if (obs_data_q[0] !== 8'hA5) begin n_errors++; $display("FAIL a5_data: got %h expected a5", obs_data_q[0]); end
      n_checks++; if (obs_dtick_q[0] !== decide_tick(s)) begin n_errors++; $display("FAIL a5_tick: got %0d expected %0d", obs_dtick_q[0], decide_tick(s)); end
    end
    n_checks++; if (obs_etick_q.size() !== 0) begin n_errors++; $display("FAIL a5_err_count: got %0d expected 0", obs_etick_q.size()); end
    n_checks++; if (data !== 8'hA5) begin n_errors++; $display("FAIL a5_data_hold: got %h expected a5", data); end
  endtask

  task automatic test_false_start();
    int s;
    clear_obs();
    play_idle(2);
    repeat (4) tick(1'b0);
    play_idle(16);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL glitch_busy: got %b expected 0", busy); end
    n_checks++; if (obs_data_q.size() + obs_etick_q.size() !== 0) begin n_errors++; $display("FAIL glitch_pulses: got %0d expected 0", obs_data_q.size() + obs_etick_q.size()); end
    play_frame(8'h3C, 1'b1, -1, s);
    play_idle(3);
    last_data = 8'h3C;
    n_checks++;
    if (obs_data_q.size() !== 1) begin
      n_errors++; $display("FAIL glitch_3c_count: got %0d expected 1", obs_data_q.size());
    end else begin
      n_checks++; if (obs_data_q[0] !== 8'h3C) begin n_errors++; $display("FAIL glitch_3c_data: got %h expected 3c", obs_data_q[0]); end
    end
  endtask

  task automatic test_framing_error();
    int s;
    clear_obs();
    play_idle(2);
    s = tick_no + 1;
    for (int t = 0; t < 9 * OS; t++) tick(frame_lvl(8'h55, 1'b0, t));
    repeat (3 * OS) tick(1'b0);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL break_busy: got %b expected 1", busy); end
    play_idle(2);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL break_exit_busy: got %b expected 0", busy); end
    n_checks++;
    if (obs_etick_q.size() !== 1) begin
      n_errors++; $display("FAIL ferr_count: got %0d expected 1", obs_etick_q.size());
    end else begin
      n_checks++; if (obs_etick_q[0] !== decide_tick(s)) begin n_errors++; $display("FAIL ferr_tick: got %0d expected %0d", obs_etick_q[0], decide_tick(s)); end
    end
    n_checks++; if (obs_data_q.size() !== 0) begin n_errors++; $display("FAIL ferr_done_count: got %0d expected 0", obs_data_q.size()); end
    n_checks++; if (data !== last_data) begin n_errors++; $display("FAIL ferr_data_kept: got %h expected %h", data, last_data); end
    play_frame(8'h0F, 1'b1, -1, s);
    play_idle(3);
    last_data = 8'h0F;
    n_checks++; if (data !== 8'h0F || obs_data_q.size() !== 1) begin n_errors++; $display("FAIL ferr_next_0f: got %h/%0d expected 0f/1", data, obs_data_q.size()); end
  endtask

  task automatic test_majority();
    int s;
    logic [7:0] exp_d[$];
    int         exp_t[$];
    clear_obs();
    play_idle(2);
    play_frame(8'h00, 1'b1, 4 * OS + MID, s);
    exp_d.push_back(8'h00); exp_t.push_back(decide_tick(s));
    for (int f = 0; f < 8; f++) begin
      logic [7:0] b;
      int g;
      b = 8'($urandom);
      g = int'($urandom_range(OS, 9 * OS - 1));
      play_idle(int'($urandom_range(0, 3)));
      play_frame(b, 1'b1, g, s);
      exp_d.push_back(b); exp_t.push_back(decide_tick(s));
    end
    play_idle(3);
    last_data = exp_d[exp_d.size()-1];
    n_checks++;
    if (obs_data_q.size() !== exp_d.size()) begin
      n_errors++; $display("FAIL maj_done_count: got %0d expected %0d", obs_data_q.size(), exp_d.size());
    end else begin
      for (int i = 0; i < exp_d.size(); i++) begin
        n_checks++; if (obs_data_q[i] !== exp_d[i]) begin n_errors++; $display("FAIL maj_data[%0d]: got %h expected %h", i, obs_data_q[i], exp_d[i]); end
        n_checks++; if (obs_dtick_q[i] !== exp_t[i]) begin n_errors++; $display("FAIL maj_tick[%0d]: got %0d expected %0d", i, obs_dtick_q[i], exp_t[i]); end
      end
    end
    n_checks++; if (obs_etick_q.size() !== 0) begin n_errors++; $display("FAIL maj_err_count: got %0d expected 0", obs_etick_q.size()); end
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    clear_obs();
    play_idle(2);
    play_frame(8'hFF, 1'b1, -1, s1);
    play_frame(8'h00, 1'b1, -1, s2);
    play_idle(3);
    last_data = 8'h00;
    n_checks++;
    if (obs_data_q.size() !== 2) begin
      n_errors++; $display("FAIL b2b_count: got %0d expected 2", obs_data_q.size());
    end else begin
      n_checks++; if (obs_data_q[0] !== 8'hFF) begin n_errors++; $display("FAIL b2b_first: got %h expected ff", obs_data_q[0]); end
      n_checks++; if (obs_data_q[1] !== 8'h00) begin n_errors++; $display("FAIL b2b_second: got %h expected 00", obs_data_q[1]); end
      n_checks++; if (obs_dtick_q[1] - obs_dtick_q[0] !== 10 * OS) begin n_errors++; $display("FAIL b2b_spacing: got %0d expected %0d", obs_dtick_q[1] - obs_dtick_q[0], 10 * OS); end
    end
  endtask

  task automatic test_sync_reset();
    int s;
    clear_obs();
    play_idle(2);
    for (int t = 0; t < 5 * OS + 4; t++) tick(frame_lvl(8'h81, 1'b1, t));
    syncReset = 1'b1;
    @(negedge clk);
    syncReset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL sreset_busy: got %b expected 0", busy); end
    play_idle(2 * OS);
    n_checks++; if (obs_data_q.size() + obs_etick_q.size() !== 0) begin n_errors++; $display("FAIL sreset_pulses: got %0d expected 0", obs_data_q.size() + obs_etick_q.size()); end
    n_checks++; if (data !== last_data) begin n_errors++; $display("FAIL sreset_data_kept: got %h expected %h", data, last_data); end
    play_frame(8'h7E, 1'b1, -1, s);
    play_idle(3);
    last_data = 8'h7E;
    n_checks++; if (data !== 8'h7E || obs_data_q.size() !== 1) begin n_errors++; $display("FAIL sreset_next_7e: got %h/%0d expected 7e/1", data, obs_data_q.size()); end
  endtask

  task automatic test_hold_without_en();
    int s;
    clear_obs();
    play_idle(2);
    en = 1'b0;
    for (int i = 0; i < 40; i++) begin rx_in = 1'($urandom); @(negedge clk); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL hold_idle_busy: got %b expected 0", busy); end
    play_idle(2);
    s = tick_no + 1;
    for (int t = 0; t < 10 * OS; t++) begin
      if (t == 4 * OS + 3) begin
        for (int i = 0; i < 50; i++) begin rx_in = 1'($urandom); @(negedge clk); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL hold_frame_busy: got %b expected 1", busy); end
      end
      tick(frame_lvl(8'h96, 1'b1, t));
    end
    play_idle(3);
    last_data = 8'h96;
    n_checks++;
    if (obs_data_q.size() !== 1) begin
      n_errors++; $display("FAIL hold_count: got %0d expected 1", obs_data_q.size());
    end else begin
      n_checks++; if (obs_data_q[0] !== 8'h96) begin n_errors++; $display("FAIL hold_data: got %h expected 96", obs_data_q[0]); end
      n_checks++; if (obs_dtick_q[0] !== decide_tick(s)) begin n_errors++; $display("FAIL hold_tick: got %0d expected %0d", obs_dtick_q[0], decide_tick(s)); end
    end
  endtask

  task automatic test_reset_midframe();
    int s;
    clear_obs();
    play_idle(2);
    for (int t = 0; t < 6 * OS; t++) tick(frame_lvl(8'h5A, 1'b1, t));
    nReset = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    n_checks++; if (busy !== 1'b0 || data !== 8'h00) begin n_errors++; $display("FAIL midrst_state: got busy %b data %h expected 0/00", busy, data); end
    play_idle(2 * OS);
    n_checks++; if (obs_data_q.size() + obs_etick_q.size() !== 0) begin n_errors++; $display("FAIL midrst_pulses: got %0d expected 0", obs_data_q.size() + obs_etick_q.size()); end
    play_frame(8'hC3, 1'b1, -1, s);
    play_idle(3);
    n_checks++; if (data !== 8'hC3 || obs_data_q.size() !== 1) begin n_errors++; $display("FAIL midrst_next_c3: got %h/%0d expected c3/1", data, obs_data_q.size()); end
  endtask

  task automatic test_pulse_shape();
    n_checks++; if (both_cnt !== 0) begin n_errors++; $display("FAIL pulse_exclusive: got %0d overlaps expected 0", both_cnt); end
    n_checks++; if (wide_cnt !== 0) begin n_errors++; $display("FAIL pulse_width: got %0d wide pulses expected 0", wide_cnt); end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_false_start();
    test_framing_error();
    test_majority();
    test_back_to_back();
    test_sync_reset();
    test_hold_without_en();
    test_reset_midframe();
    test_pulse_shape();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
